mmc3_scanline_irq: RTL and testbench



---
 rtl/coolgirl_irq_pkg.sv | 19 +
 rtl/a12_edge_filter.sv | 64 ++++++
 rtl/mmc3_scanline_irq.sv | 127 ++++++++++++
 tb/tb_mmc3_scanline_irq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/coolgirl_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : coolgirl_irq_pkg
// Purpose : Shared constants for the MMC3-family scanline IRQ block.
//           - IRQ_SEL_* : reg_sel encodings for the four IRQ registers
//           - IRQ_CNT_W : width of the scanline counter and its latch
// Revision: 1.0 - initial release
// ============================================================================
package coolgirl_irq_pkg;

  localparam int unsigned IRQ_CNT_W = 8;

  localparam logic [1:0] IRQ_SEL_LATCH   = 2'd0;  // $C000
  localparam logic [1:0] IRQ_SEL_RELOAD  = 2'd1;  // $C001
  localparam logic [1:0] IRQ_SEL_DISABLE = 2'd2;  // $E000
  localparam logic [1:0] IRQ_SEL_ENABLE  = 2'd3;  // $E001

endpackage : coolgirl_irq_pkg
`default_nettype wire

// File: rtl/a12_edge_filter.sv
`default_nettype none
// ============================================================================
// Module  : a12_edge_filter
// Purpose : Synchronises PPU A12 into the m2 domain and emits a one-cycle
//           counter clock event on each rising edge that followed a long
//           enough low run.
// Ports   : m2      - CPU M2 clock, all flops on posedge
//           rst_n   - asynchronous active-low reset
//           ppu_a12 - raw PPU A12 (asynchronous to m2)
//           clk_ev  - counter clock event, consumed at the next m2 edge
// Params  : A12_LOW_MIN - low samples required before a rise counts
//           LOW_CNT_W   - low-run counter width, 2^LOW_CNT_W-1 >= A12_LOW_MIN
// Revision: 1.0 - initial release
// ============================================================================
module a12_edge_filter
  import coolgirl_irq_pkg::*;
#(
  parameter int A12_LOW_MIN = 3,
  parameter int LOW_CNT_W   = 3
) (
  input  logic m2,
  input  logic rst_n,
  input  logic ppu_a12,
  output logic clk_ev
);

  localparam logic [LOW_CNT_W-1:0] LOW_MIN_C  = LOW_CNT_W'(A12_LOW_MIN);
  localparam logic [LOW_CNT_W-1:0] LOW_FULL_C = '1;

  logic                 a12_s1_q;
  logic                 a12_s2_q;
  logic [LOW_CNT_W-1:0] low_cnt_q;
  logic [LOW_CNT_W-1:0] low_cnt_d;

  // a12_s1_q is exactly the value a12_s2 takes at the coming edge, and
  // a12_s2_q is the "previous a12_s2" for that edge. Evaluating the event on
  // this pair lets the counter update on the same edge that a12_s2 rises.
  // low_cnt_q always holds the low-run length ending at the current a12_s2_q.
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (a12_s1_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_FULL_C) begin
      low_cnt_d = low_cnt_q + LOW_CNT_W'(1);
    end
  end

  assign clk_ev = a12_s1_q & ~a12_s2_q & (low_cnt_q >= LOW_MIN_C);

  // low_cnt resets saturated so the first rise after reset is not filtered.
  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      a12_s1_q  <= 1'b0;
      a12_s2_q  <= 1'b0;
      low_cnt_q <= LOW_FULL_C;
    end else begin
      a12_s1_q  <= ppu_a12;
      a12_s2_q  <= a12_s1_q;
      low_cnt_q <= low_cnt_d;
    end
  end

endmodule : a12_edge_filter
`default_nettype wire

// File: rtl/mmc3_scanline_irq.sv
`default_nettype none
// ============================================================================
// Module  : mmc3_scanline_irq
// Purpose : MMC3 scanline IRQ: filtered A12 rises clock an 8-bit down-counter
//           that reloads from a latch; hitting zero raises irq_pending.
// Ports   : m2          - CPU M2 clock
//           rst_n       - asynchronous active-low reset
//           ppu_a12     - raw PPU A12
//           reg_we      - one-cycle IRQ register write strobe
//           reg_sel     - 0 latch, 1 reload, 2 disable, 3 enable
//           reg_data    - write data (latch only)
//           irq_pending - active-high IRQ request
//           irq_counter - current counter value
// Config  : `define MMC3_IRQ_REV_A_EN selects Rev A (Sharp) IRQ qualification;
//           undefined builds Rev B (NEC) behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module mmc3_scanline_irq
  import coolgirl_irq_pkg::*;
#(
  parameter int A12_LOW_MIN = 3,
  parameter int LOW_CNT_W   = 3
) (
  input  logic                 m2,
  input  logic                 rst_n,
  input  logic                 ppu_a12,
  input  logic                 reg_we,
  input  logic [1:0]           reg_sel,
  input  logic [7:0]           reg_data,
  output logic                 irq_pending,
  output logic [IRQ_CNT_W-1:0] irq_counter
);

  logic                 clk_ev;
  logic [IRQ_CNT_W-1:0] latch_q,   latch_d;
  logic [IRQ_CNT_W-1:0] counter_q, counter_d;
  logic                 reload_q,  reload_d;
  logic                 enabled_q, enabled_d;
  logic                 pending_q, pending_d;
  logic                 irq_set;
  logic                 wr_latch, wr_reload, wr_disable, wr_enable;

  a12_edge_filter #(
    .A12_LOW_MIN (A12_LOW_MIN),
    .LOW_CNT_W   (LOW_CNT_W)
  ) u_a12_filter (
    .m2      (m2),
    .rst_n   (rst_n),
    .ppu_a12 (ppu_a12),
    .clk_ev  (clk_ev)
  );

  assign wr_latch   = reg_we && (reg_sel == IRQ_SEL_LATCH);
  assign wr_reload  = reg_we && (reg_sel == IRQ_SEL_RELOAD);
  assign wr_disable = reg_we && (reg_sel == IRQ_SEL_DISABLE);
  assign wr_enable  = reg_we && (reg_sel == IRQ_SEL_ENABLE);

  // Ordering below encodes same-edge priority: the clock event works on
  // pre-write state, then register writes override (reload beats the
  // counter update, disable beats an IRQ set).
  always_comb begin
    latch_d   = latch_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    enabled_d = enabled_q;
    pending_d = pending_q;
    irq_set   = 1'b0;

    if (clk_ev) begin
      // Zero always reloads, so the decrement never wraps.
      if ((counter_q == '0) || reload_q) begin
        counter_d = latch_q;
        reload_d  = 1'b0;
      end else begin
        counter_d = counter_q - IRQ_CNT_W'(1);
      end
`ifdef MMC3_IRQ_REV_A_EN
      // Rev A only fires on a transition into zero (or a forced reload),
      // so a zero latch fires once and then stays silent.
      irq_set = (counter_d == '0) && ((counter_q != '0) || reload_q);
`else
      irq_set = (counter_d == '0);
`endif
    end

    // An enable write landing on the same edge still lets the IRQ through.
    if (irq_set && (enabled_q || wr_enable)) begin
      pending_d = 1'b1;
    end

    if (wr_latch) begin
      latch_d = reg_data;
    end
    if (wr_reload) begin
      counter_d = '0;
      reload_d  = 1'b1;
    end
    if (wr_disable) begin
      enabled_d = 1'b0;
      pending_d = 1'b0;
    end
    if (wr_enable) begin
      enabled_d = 1'b1;
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= '0;
      counter_q <= '0;
      reload_q  <= 1'b0;
      enabled_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      enabled_q <= enabled_d;
      pending_q <= pending_d;
    end
  end

  assign irq_pending = pending_q;
  assign irq_counter = counter_q;

endmodule : mmc3_scanline_irq
`default_nettype wire

// File: tb/tb_mmc3_scanline_irq.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmc3_scanline_irq
// Purpose : Directed self-checking bench for mmc3_scanline_irq.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mmc3_scanline_irq;
  import coolgirl_irq_pkg::*;

  logic       m2;
  logic       rst_n;
  logic       ppu_a12;
  logic       reg_we;
  logic [1:0] reg_sel;
  logic [7:0] reg_data;
  logic       irq_pending;
  logic [7:0] irq_counter;

  int n_cmp;
  int n_err;

  mmc3_scanline_irq #(
    .A12_LOW_MIN (3),
    .LOW_CNT_W   (3)
  ) dut (
    .m2          (m2),
    .rst_n       (rst_n),
    .ppu_a12     (ppu_a12),
    .reg_we      (reg_we),
    .reg_sel     (reg_sel),
    .reg_data    (reg_data),
    .irq_pending (irq_pending),
    .irq_counter (irq_counter)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    reg_we   = 1'b1;
    reg_sel  = sel;
    reg_data = data;
    tick();
    reg_we   = 1'b0;
  endtask

  // A12 low for low_n samples, then high for two; the counter clocks on
  // the second high edge.
  task automatic pulse(input int low_n);
    ppu_a12 = 1'b0;
    repeat (low_n) tick();
    ppu_a12 = 1'b1;
    tick();
    tick();
  endtask

  // Same as pulse, with a register write on the counter-clocking edge.
  task automatic pulse_wr(input int low_n, input logic [1:0] sel, input logic [7:0] data);
    ppu_a12 = 1'b0;
    repeat (low_n) tick();
    ppu_a12 = 1'b1;
    tick();
    wr(sel, data);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    ppu_a12  = 1'b0;
    reg_we   = 1'b0;
    reg_sel  = 2'd0;
    reg_data = 8'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_pending", {7'd0, irq_pending}, 8'd0);
    check("reset_counter", irq_counter, 8'd0);

    // Basic count: latch 3 -> 3,2,1,0,3 with IRQ on the 4th pulse
    wr(IRQ_SEL_LATCH, 8'd3);
    wr(IRQ_SEL_RELOAD, 8'd0);
    wr(IRQ_SEL_ENABLE, 8'd0);
    pulse(4); check("p1_counter", irq_counter, 8'd3);
    check("p1_pending", {7'd0, irq_pending}, 8'd0);
    pulse(4); check("p2_counter", irq_counter, 8'd2);
    pulse(4); check("p3_counter", irq_counter, 8'd1);
    check("p3_pending", {7'd0, irq_pending}, 8'd0);
    pulse(4); check("p4_counter", irq_counter, 8'd0);
    check("p4_pending", {7'd0, irq_pending}, 8'd1);
    pulse(4); check("p5_counter", irq_counter, 8'd3);
    check("p5_pending", {7'd0, irq_pending}, 8'd1);

    // Disable clears pending; disable on a zero-hitting edge wins
    wr(IRQ_SEL_DISABLE, 8'd0);
    check("dis_pending", {7'd0, irq_pending}, 8'd0);
    wr(IRQ_SEL_ENABLE, 8'd0);
    pulse(4); check("d1_counter", irq_counter, 8'd2);
    pulse(4); check("d2_counter", irq_counter, 8'd1);
    pulse_wr(4, IRQ_SEL_DISABLE, 8'd0);
    check("dis_ev_counter", irq_counter, 8'd0);
    check("dis_ev_pending", {7'd0, irq_pending}, 8'd0);

    // Low-run filter: 2 low samples rejected, exactly 3 accepted
    pulse(2); check("short_low_counter", irq_counter, 8'd0);
    pulse(3); check("min_low_counter", irq_counter, 8'd3);

    // Enable write on the zero-hitting edge lets the IRQ set
    pulse(4); check("e1_counter", irq_counter, 8'd2);
    pulse(4); check("e2_counter", irq_counter, 8'd1);
    check("e2_pending", {7'd0, irq_pending}, 8'd0);
    pulse_wr(4, IRQ_SEL_ENABLE, 8'd0);
    check("en_ev_counter", irq_counter, 8'd0);
    check("en_ev_pending", {7'd0, irq_pending}, 8'd1);

    // Latch of zero: Rev A fires once, Rev B every scanline
    wr(IRQ_SEL_DISABLE, 8'd0);
    wr(IRQ_SEL_LATCH, 8'd0);
    wr(IRQ_SEL_RELOAD, 8'd0);
    wr(IRQ_SEL_ENABLE, 8'd0);
    check("z_reload_counter", irq_counter, 8'd0);
    check("z_pre_pending", {7'd0, irq_pending}, 8'd0);
    pulse(4); check("z1_pending", {7'd0, irq_pending}, 8'd1);
    check("z1_counter", irq_counter, 8'd0);
    wr(IRQ_SEL_DISABLE, 8'd0);
    wr(IRQ_SEL_ENABLE, 8'd0);
    check("z1_cleared", {7'd0, irq_pending}, 8'd0);
    pulse(4);
`ifdef MMC3_IRQ_REV_A_EN
    check("z2_pending", {7'd0, irq_pending}, 8'd0);
`else
    check("z2_pending", {7'd0, irq_pending}, 8'd1);
`endif
    wr(IRQ_SEL_DISABLE, 8'd0);
    wr(IRQ_SEL_ENABLE, 8'd0);
    pulse(4);
`ifdef MMC3_IRQ_REV_A_EN
    check("z3_pending", {7'd0, irq_pending}, 8'd0);
`else
    check("z3_pending", {7'd0, irq_pending}, 8'd1);
`endif

    // Reload write on the same edge as a clock event with counter 5
    wr(IRQ_SEL_DISABLE, 8'd0);
    wr(IRQ_SEL_LATCH, 8'd5);
    wr(IRQ_SEL_RELOAD, 8'd0);
    wr(IRQ_SEL_ENABLE, 8'd0);
    pulse(4); check("r_load_counter", irq_counter, 8'd5);
    wr(IRQ_SEL_LATCH, 8'd7);
    pulse_wr(4, IRQ_SEL_RELOAD, 8'd0);
    check("r_same_edge_counter", irq_counter, 8'd0);
    pulse(4); check("r_next_counter", irq_counter, 8'd7);

    // Asynchronous reset mid-count with an IRQ pending
    wr(IRQ_SEL_LATCH, 8'd2);
    wr(IRQ_SEL_RELOAD, 8'd0);
    pulse(4); check("x1_counter", irq_counter, 8'd2);
    pulse(4); check("x2_counter", irq_counter, 8'd1);
    pulse(4); check("x3_counter", irq_counter, 8'd0);
    check("x3_pending", {7'd0, irq_pending}, 8'd1);
    pulse(4); check("x4_counter", irq_counter, 8'd2);
    #2;
    rst_n   = 1'b0;
    ppu_a12 = 1'b0;
    #1;
    check("async_rst_pending", {7'd0, irq_pending}, 8'd0);
    check("async_rst_counter", irq_counter, 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wr(IRQ_SEL_LATCH, 8'd4);
    check("post_rst_pending", {7'd0, irq_pending}, 8'd0);
    ppu_a12 = 1'b1;
    tick();
    check("post_rst_latency", irq_counter, 8'd0);
    tick();
    check("post_rst_first_rise", irq_counter, 8'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mmc3_scanline_irq
`default_nettype wire
